// File: rtl/regfile_ctx_pkg.sv
// rtl/regfile_ctx_pkg.sv - shared types and constants for the register-file context engine
//
// Purpose: state enumeration, transfer-direction encodings and word size used
//          by regfile_ctx_engine and its testbench.
// Ports:   none (package).
package regfile_ctx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SREQ = 3'd1,
        RREQ = 3'd2,
        RWB  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic MODE_SAVE    = 1'b0;
    localparam logic MODE_RESTORE = 1'b1;
    localparam int   WORD_BYTES   = 4;

    // Save areas are word aligned; the low two address bits are discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/regfile_ctx_engine_if.sv
// rtl/regfile_ctx_engine_if.sv - memory request/response bus of the context engine
//
// Purpose: groups the single-outstanding memory request channel.
// Signals: mem_req/mem_we/mem_addr/mem_wdata  request, held until acknowledged
//          mem_ack                            transfer completes this cycle
//          mem_rdata                          read data, valid only with mem_ack
// Modports: master (engine side), slave (memory side).
interface regfile_ctx_engine_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/regfile_ctx_engine.sv
// rtl/regfile_ctx_engine.sv - saves/restores a register-file range to/from memory
//
// Purpose: on start, copies registers FIRST_REG..LAST_REG to consecutive words
//          at base (save, mode=0) or loads them back from there (restore, mode=1).
// Ports:   clk, reset              clock, synchronous active-high reset
//          start, mode, base       operation request (sampled only in IDLE)
//          busy, done              status, done is a one-cycle pulse
//          rf_ra / rf_rd           regfile read port (rf_rd combinational)
//          rf_we, rf_wa, rf_wd     regfile write port
//          mem                     memory request bus (master side)
module regfile_ctx_engine
    import regfile_ctx_pkg::*;
#(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        mode,
    input  logic [31:0]                 base,
    output logic                        busy,
    output logic                        done,
    output logic [4:0]                  rf_ra,
    input  logic [31:0]                 rf_rd,
    output logic                        rf_we,
    output logic [4:0]                  rf_wa,
    output logic [31:0]                 rf_wd,
    regfile_ctx_engine_if.master        mem
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    state_t      state;
    logic [4:0]  idx;
    logic [31:0] base_q;
    logic [31:0] buf_q;
    logic [31:0] next_addr;

    logic        busy_q;
    logic        done_q;
    logic [4:0]  rf_ra_q;
    logic        rf_we_q;
    logic [4:0]  rf_wa_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;

    // Address of the word for register idx+1; wraps modulo 2^32.
    assign next_addr = base_q + 32'(idx - FIRST_IDX + 5'd1) * 32'(WORD_BYTES);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= FIRST_IDX;
            base_q     <= '0;
            buf_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rf_ra_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_wa_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q     <= align_word(base);
                        mem_addr_q <= align_word(base);
                        idx        <= FIRST_IDX;
                        busy_q     <= 1'b1;
                        mem_req_q  <= 1'b1;
                        if (mode == MODE_SAVE) begin
                            state    <= SREQ;
                            mem_we_q <= 1'b1;
                            rf_ra_q  <= FIRST_IDX;
                        end else begin
                            state    <= RREQ;
                        end
                    end
                end

                SREQ: begin
                    if (mem.mem_ack) begin
                        if (idx == LAST_IDX) begin
                            state      <= DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            mem_req_q  <= 1'b0;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= '0;
                            rf_ra_q    <= '0;
                        end else begin
                            idx        <= idx + 5'd1;
                            rf_ra_q    <= idx + 5'd1;
                            mem_addr_q <= next_addr;
                        end
                    end
                end

                RREQ: begin
                    if (mem.mem_ack) begin
                        state      <= RWB;
                        buf_q      <= mem.mem_rdata;
                        mem_req_q  <= 1'b0;
                        mem_addr_q <= '0;
                        rf_we_q    <= 1'b1;
                        rf_wa_q    <= idx;
                    end
                end

                RWB: begin
                    rf_we_q <= 1'b0;
                    rf_wa_q <= '0;
                    if (idx == LAST_IDX) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state      <= RREQ;
                        idx        <= idx + 5'd1;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= next_addr;
                    end
                end

                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rf_ra = rf_ra_q;
    assign rf_wa = rf_wa_q;
    // The regfile samples rf_we on the same edge that applies reset, so reset
    // must suppress the write-back combinationally to abort it cleanly.
    assign rf_we = rf_we_q & ~reset;
    assign rf_wd = rf_we_q ? buf_q : '0;

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    // Save data comes straight from the combinational regfile read port.
    assign mem.mem_wdata = mem_we_q ? rf_rd : '0;

endmodule

// File: doc/regfile_ctx_engine.md
REGFILE_CTX_ENGINE -- requirements
Module: regfile_ctx_engine

Interface
REQ-001 SHALL have parameter FIRST_REG, default 1, lowest register index transferred; legal range 1..LAST_REG.
REQ-002 SHALL have parameter LAST_REG, default 31, highest register index transferred; legal range FIRST_REG..31.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the block's only clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-006 SHALL have port mode  input  1  0 = save (regfile to memory), 1 = restore (memory to regfile).
REQ-007 SHALL have port base  input  32  byte base address of the save area.
REQ-008 SHALL have port busy  output  1  operation in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rf_ra  output  5  regfile read address.
REQ-011 SHALL have port rf_rd  input  32  regfile read data, combinational from rf_ra.
REQ-012 SHALL have ports rf_we  output  1, rf_wa  output  5, and rf_wd  output  32, forming the regfile write port.
REQ-013 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  32, and mem_wdata  output  32, forming the memory request.
REQ-014 SHALL have ports mem_ack  input  1 and mem_rdata  input  32; mem_rdata is valid only in a cycle where mem_ack is 1.

Function
REQ-015 SHALL implement states IDLE, SREQ, RREQ, RWB and DONE, held in a registered index idx, latched base_q and a 32-bit restore buffer.
REQ-016 In IDLE with start=1, SHALL latch base with bits [1:0] forced to 00, set idx=FIRST_REG, and go to SREQ (mode=0) or RREQ (mode=1).
REQ-017 SHALL ignore start and mode in every state other than IDLE.
REQ-018 In SREQ, SHALL drive: rf_ra=idx, mem_req=1, mem_we=1, mem_addr=base_q+4*(idx-FIRST_REG), mem_wdata=rf_rd.
REQ-019 SHALL hold all SREQ and RREQ request outputs stable until mem_ack=1.
REQ-020 On mem_ack in SREQ, SHALL go to DONE if idx==LAST_REG, else increment idx and stay in SREQ.
REQ-021 In RREQ, SHALL drive mem_req=1, mem_we=0 and the same mem_addr as SREQ.
REQ-022 On mem_ack in RREQ, SHALL capture mem_rdata into the buffer and go to RWB.
REQ-023 In RWB, SHALL assert rf_we=1 for exactly one cycle with rf_wa=idx and rf_wd=buffer, then go to DONE if idx==LAST_REG, else increment idx and go to RREQ.
REQ-024 SHALL never assert rf_we with rf_wa=0.
REQ-025 SHALL compute mem_addr modulo 2^32; base 32'hFFFFFFFC wraps to 0 for the second word.
REQ-026 mem_ack MAY arrive in the first request cycle (zero wait); in IDLE, RWB and DONE, SHALL ignore mem_ack.
REQ-027 With zero-wait memory and default parameters: save SHALL take 31 cycles plus DONE; restore SHALL take 62 cycles plus DONE.
REQ-028 busy SHALL be 1 in SREQ, RREQ and RWB, and 0 in IDLE and DONE.
REQ-029 In DONE, SHALL assert done=1 for one cycle, then go to IDLE; a start arriving in the DONE cycle is ignored.
REQ-030 Outside their active states, SHALL drive rf_we, mem_req, mem_we, rf_wa, rf_wd, mem_addr and mem_wdata to 0, and rf_ra to 0.

Reset
REQ-031 On reset=1 at posedge clk, SHALL enter IDLE, set idx=FIRST_REG, and clear base_q and the buffer.
REQ-032 Reset SHALL take priority over all other inputs, including start and mem_ack in the same cycle.
REQ-033 Reset mid-operation SHALL abort without completing the pending transfer: no rf_we, no done, and mem_req=0 from the next cycle.

Structure
REQ-034 Package regfile_ctx_pkg SHALL hold the state enumeration, MODE_SAVE=0, MODE_RESTORE=1 and WORD_BYTES=4.
REQ-035 SHALL be a single flat module with no sub-module; the regfile and memory are external.

Verification
REQ-036 Save, regs 1..31 hold 32'h100+i, base=32'h200, zero-wait ack -> word 32'h200+4*(i-1) = 32'h100+i, done at cycle 32, no rf_we.
REQ-037 Restore, memory preloaded with 32'hA000+i, base=32'h200, ack delayed 3 cycles -> each reg i = 32'hA000+i, exactly 31 rf_we pulses, request held stable during waits.
REQ-038 base=32'h0000_0203 -> first mem_addr=32'h200; base=32'hFFFFFFFC -> second mem_addr=32'h0.
REQ-039 start pulsed while busy, and mem_ack pulsed in IDLE -> no effect, single done pulse per operation.
REQ-040 reset asserted in the RWB cycle for idx=5 -> rf_we=0 that edge, busy=0, regs 5..31 unchanged, next start begins at idx=1.
REQ-041 FIRST_REG=28, LAST_REG=30 save -> exactly 3 writes at base, base+4 and base+8, done after 3 cycles.
